// File: rtl/mch_enc_p2s_param_pkg.sv
// Shared types and helpers for the parametrised Manchester encoder.
// Holds the FSM state type, encoding constants, counter sizing and the half-bit level function.
package mch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PRE  = 2'd1,
    DATA = 2'd2,
    GAP  = 2'd3
  } mch_state_e;

  localparam logic MCH_THOMAS = 1'b0;
  localparam logic MCH_IEEE   = 1'b1;

  // Width wide enough for the half-bit, data, preamble and gap counters.
  function automatic int mch_cnt_width(input int half_div, input int dw,
                                       input int pre_len, input int gap_bits);
    int m;
    m = half_div;
    if (dw > m) m = dw;
    if (pre_len > m) m = pre_len;
    if (gap_bits > m) m = gap_bits;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

  // Line level of one half-bit: the first half is b ^ pol, the second its complement.
  function automatic logic mch_half_level(input logic b, input logic pol, input logic phase);
    return b ^ pol ^ phase;
  endfunction

endpackage

// File: rtl/mch_enc_p2s_param_if.sv
// Valid/ready parallel frame bus feeding the Manchester encoder.
// DW must match the DW of the encoder the bus is connected to.
interface mch_enc_p2s_param_if #(
  parameter int DW = 8
) ();
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] pd;

  modport master (output in_valid, output pd, input in_ready);
  modport slave  (input in_valid, input pd, output in_ready);
endinterface

// File: rtl/mch_enc_p2s_param_half_tick.sv
// Half-bit divider: counts HALF_DIV clocks per half-bit while running.
// Restart realigns it to the start of a fresh first half-bit.
module mch_half_tick #(
  parameter int HALF_DIV = 50,
  parameter int CW       = 6
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic restart,
  output logic tick,
  output logic phase
);

  localparam logic [CW-1:0] LAST = CW'(HALF_DIV - 1);

  logic [CW-1:0] cnt_r;
  logic          phase_r;

  assign tick  = run & (cnt_r == LAST);
  assign phase = phase_r;

  // Half-bit counter and phase register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r   <= '0;
      phase_r <= 1'b0;
    end else if (restart || !run) begin
      cnt_r   <= '0;
      phase_r <= 1'b0;
    end else if (cnt_r == LAST) begin
      cnt_r   <= '0;
      phase_r <= ~phase_r;
    end else begin
      cnt_r   <= cnt_r + CW'(1);
    end
  end

endmodule

// File: rtl/mch_enc_p2s_param.sv
// Manchester encoder with one-entry holding buffer, optional preamble and inter-frame gap.
// sdo lags the internal state by one clock, so the first half-bit appears two clocks after accept.
module mch_enc_p2s_param
  import mch_pkg::*;
#(
  parameter int DW        = 8,
  parameter int HALF_DIV  = 50,
  parameter int MSB_FIRST = 1,
  parameter int POL       = 0,
  parameter int IDLE_LVL  = 1,
  parameter int PRE_LEN   = 0,
  parameter int GAP_BITS  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  mch_enc_p2s_param_if.slave    bus,
  output logic                  sdo,
  output logic                  busy,
  output logic                  done
);

  localparam int         CW       = mch_cnt_width(HALF_DIV, DW, PRE_LEN, GAP_BITS);
  localparam logic       POL_B    = (POL == int'(MCH_IEEE));
  localparam logic       IDLE_B   = (IDLE_LVL != 0);
  localparam mch_state_e FIRST_ST = (PRE_LEN > 0) ? PRE : DATA;

  mch_state_e    state_r, state_s;
  logic          full_r;
  logic [DW-1:0] hold_r, shift_r;
  logic [CW-1:0] bit_cnt_r;
  logic          sdo_r, busy_r, done_r;
  logic          sdo_s, launch_s, bit_clr_s, data_last_s;
  logic          accept_s, run_s, tick_s, phase_s, bit_end_s, cur_bit_s, pre_bit_s;

  assign accept_s     = bus.in_valid & ~full_r;
  assign bus.in_ready = ~full_r;
  assign run_s        = (state_r != IDLE);
  assign bit_end_s    = tick_s & phase_s;
  assign cur_bit_s    = (MSB_FIRST != 0) ? shift_r[DW-1] : shift_r[0];
  assign pre_bit_s    = ~bit_cnt_r[0];
  assign sdo          = sdo_r;
  assign busy         = busy_r;
  assign done         = done_r;

  mch_half_tick #(.HALF_DIV(HALF_DIV), .CW(CW)) u_half_tick (
    .clk     (clk),
    .rst     (rst),
    .run     (run_s),
    .restart (launch_s),
    .tick    (tick_s),
    .phase   (phase_s)
  );

  // Next-state decode; launch pulls the held frame into the shifter.
  always_comb begin
    state_s     = state_r;
    launch_s    = 1'b0;
    bit_clr_s   = 1'b0;
    data_last_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (full_r) begin
          launch_s  = 1'b1;
          bit_clr_s = 1'b1;
          state_s   = FIRST_ST;
        end else begin
          state_s   = IDLE;
        end
      end
      PRE: begin
        if (bit_end_s && (bit_cnt_r == CW'(PRE_LEN - 1))) begin
          state_s   = DATA;
          bit_clr_s = 1'b1;
        end else begin
          state_s   = PRE;
        end
      end
      DATA: begin
        if (bit_end_s && (bit_cnt_r == CW'(DW - 1))) begin
          data_last_s = 1'b1;
          bit_clr_s   = 1'b1;
          if (GAP_BITS > 0) begin
            state_s  = GAP;
          end else if (full_r) begin
            launch_s = 1'b1;
            state_s  = FIRST_ST;
          end else begin
            state_s  = IDLE;
          end
        end else begin
          state_s = DATA;
        end
      end
      GAP: begin
        if (bit_end_s && (bit_cnt_r == CW'(GAP_BITS - 1))) begin
          bit_clr_s = 1'b1;
          if (full_r) begin
            launch_s = 1'b1;
            state_s  = FIRST_ST;
          end else begin
            state_s  = IDLE;
          end
        end else begin
          state_s = GAP;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // Line level for the next clock.
  always_comb begin
    sdo_s = IDLE_B;
    case (state_r)
      PRE:     sdo_s = mch_half_level(pre_bit_s, POL_B, phase_s);
      DATA:    sdo_s = mch_half_level(cur_bit_s, POL_B, phase_s);
      default: sdo_s = IDLE_B;
    endcase
  end

  // Holding buffer: pd is only sampled on an accepted handshake.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      full_r <= 1'b0;
      hold_r <= '0;
    end else begin
      full_r <= accept_s | (full_r & ~launch_s);
      if (accept_s) hold_r <= bus.pd;
    end
  end

  // State, shifter, bit counter and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= IDLE;
      shift_r   <= '0;
      bit_cnt_r <= '0;
      sdo_r     <= IDLE_B;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      state_r <= state_s;
      if (launch_s) begin
        shift_r <= hold_r;
      end else if ((state_r == DATA) && bit_end_s) begin
        shift_r <= (MSB_FIRST != 0) ? (shift_r << 1) : (shift_r >> 1);
      end
      if (bit_clr_s || !run_s) begin
        bit_cnt_r <= '0;
      end else if (bit_end_s) begin
        bit_cnt_r <= bit_cnt_r + CW'(1);
      end
      sdo_r  <= sdo_s;
      busy_r <= (state_s != IDLE);
      done_r <= data_last_s;
    end
  end

endmodule

// File: tb/tb_mch_enc_p2s_param.sv
// Bench for mch_enc_p2s_param: four instances with different settings, a frame scoreboard
// built from the encoding rules, and half-bit-exact comparison of sdo and done.
module tb_mch_enc_p2s_param;

  localparam int H = 4;
  // Per-instance settings: 0 default/gap1, 1 IEEE+LSB-first, 2 no gap, 3 preamble 4.
  localparam logic [3:0] POL_C = 4'b0010;
  localparam logic [3:0] MSB_C = 4'b1101;
  localparam int PRE_C [4] = '{0, 0, 0, 4};
  localparam int GAP_C [4] = '{1, 1, 0, 1};

  typedef struct {
    int          n;
    logic [31:0] h;
  } frame_t;

  logic        clk = 1'b0;
  logic        rst;
  int          cyc = 0;
  logic [3:0]  valid_v;
  logic [7:0]  pd_v [4];
  wire  [3:0]  sdo_v, busy_v, done_v, rdy_v;
  frame_t      exp_q [$];
  int          checks = 0;
  int          failures = 0;
  int          acc_first = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mch_enc_p2s_param_if #(.DW(8)) bus_a ();
  mch_enc_p2s_param_if #(.DW(8)) bus_b ();
  mch_enc_p2s_param_if #(.DW(8)) bus_c ();
  mch_enc_p2s_param_if #(.DW(8)) bus_d ();

  assign bus_a.in_valid = valid_v[0];
  assign bus_a.pd       = pd_v[0];
  assign rdy_v[0]       = bus_a.in_ready;
  assign bus_b.in_valid = valid_v[1];
  assign bus_b.pd       = pd_v[1];
  assign rdy_v[1]       = bus_b.in_ready;
  assign bus_c.in_valid = valid_v[2];
  assign bus_c.pd       = pd_v[2];
  assign rdy_v[2]       = bus_c.in_ready;
  assign bus_d.in_valid = valid_v[3];
  assign bus_d.pd       = pd_v[3];
  assign rdy_v[3]       = bus_d.in_ready;

  mch_enc_p2s_param #(.DW(8), .HALF_DIV(H), .MSB_FIRST(1), .POL(0), .IDLE_LVL(1),
                      .PRE_LEN(0), .GAP_BITS(1)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a), .sdo(sdo_v[0]), .busy(busy_v[0]), .done(done_v[0]));
  mch_enc_p2s_param #(.DW(8), .HALF_DIV(H), .MSB_FIRST(0), .POL(1), .IDLE_LVL(1),
                      .PRE_LEN(0), .GAP_BITS(1)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b), .sdo(sdo_v[1]), .busy(busy_v[1]), .done(done_v[1]));
  mch_enc_p2s_param #(.DW(8), .HALF_DIV(H), .MSB_FIRST(1), .POL(0), .IDLE_LVL(1),
                      .PRE_LEN(0), .GAP_BITS(0)) dut_c (
    .clk(clk), .rst(rst), .bus(bus_c), .sdo(sdo_v[2]), .busy(busy_v[2]), .done(done_v[2]));
  mch_enc_p2s_param #(.DW(8), .HALF_DIV(H), .MSB_FIRST(1), .POL(0), .IDLE_LVL(1),
                      .PRE_LEN(4), .GAP_BITS(1)) dut_d (
    .clk(clk), .rst(rst), .bus(bus_d), .sdo(sdo_v[3]), .busy(busy_v[3]), .done(done_v[3]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic fail_now(input string tag);
    checks++;
    failures++;
    $error("FAIL %s bound expired", tag);
  endtask

  // Expected half-bit levels in line order: preamble 1,0,1,0..., then data.
  function automatic frame_t model(input int id, input logic [7:0] d);
    frame_t f;
    logic   b, lv;
    f.n = 0;
    f.h = '0;
    for (int p = 0; p < PRE_C[id]; p++) begin
      b = ((p % 2) == 0);
      lv = b ^ POL_C[id];
      f.h[f.n] = lv;
      f.h[f.n + 1] = ~lv;
      f.n += 2;
    end
    for (int i = 0; i < 8; i++) begin
      b = MSB_C[id] ? d[7 - i] : d[i];
      lv = b ^ POL_C[id];
      f.h[f.n] = lv;
      f.h[f.n + 1] = ~lv;
      f.n += 2;
    end
    return f;
  endfunction

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic drive(input int id, input logic [7:0] d, output int acc_cyc, output int rdy_cyc);
    bit ok;
    ok = 1'b0;
    acc_cyc = -1;
    rdy_cyc = -1;
    valid_v[id] = 1'b1;
    for (int t = 0; t < 400; t++) begin
      if (rdy_v[id]) begin
        pd_v[id] = d;
        rdy_cyc = cyc;
        exp_q.push_back(model(id, d));
        @(negedge clk);
        acc_cyc = cyc;
        ok = 1'b1;
        break;
      end else begin
        pd_v[id] = 8'($urandom);
        @(negedge clk);
      end
    end
    if (!ok) fail_now("accept_wait");
  endtask

  task automatic check_stream(input int id, input int nfr, input string tag);
    frame_t f;
    bit     seen;
    seen = 1'b0;
    for (int t = 0; t < 400; t++) begin
      @(negedge clk);
      if (busy_v[id]) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      fail_now({tag, "_busy_wait"});
      return;
    end
    chk({tag, "_sdo_before_first_half"}, 32'(sdo_v[id]), 32'd1);
    for (int fr = 0; fr < nfr; fr++) begin
      if (exp_q.size() == 0) begin
        fail_now({tag, "_scoreboard_empty"});
        return;
      end
      f = exp_q.pop_front();
      for (int k = 0; k < f.n; k++) begin
        for (int c = 0; c < H; c++) begin
          @(negedge clk);
          if (fr == 0 && k == 0 && c == 0) chk({tag, "_latency"}, 32'(cyc - acc_first), 32'd2);
          chk({tag, "_sdo"}, 32'(sdo_v[id]), 32'(f.h[k]));
          chk({tag, "_done"}, 32'(done_v[id]), 32'((k == f.n - 1) && (c == H - 1)));
        end
      end
      for (int g = 0; g < GAP_C[id] * 2 * H; g++) begin
        @(negedge clk);
        chk({tag, "_gap_sdo"}, 32'(sdo_v[id]), 32'd1);
        chk({tag, "_gap_done"}, 32'(done_v[id]), 32'd0);
      end
    end
    @(negedge clk);
    chk({tag, "_busy_end"}, 32'(busy_v[id]), 32'd0);
    chk({tag, "_sdo_end"}, 32'(sdo_v[id]), 32'd1);
    chk({tag, "_sb_drained"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int     a1, a2, a3, r1, r2, r3;
    frame_t fr0;
    rst = 1'b0;
    valid_v = 4'b0000;
    for (int i = 0; i < 4; i++) pd_v[i] = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      chk("reset_sdo", 32'(sdo_v[i]), 32'd1);
      chk("reset_busy", 32'(busy_v[i]), 32'd0);
      chk("reset_done", 32'(done_v[i]), 32'd0);
      chk("reset_ready", 32'(rdy_v[i]), 32'd1);
    end

    // Thomas, MSB first, one gap bit.
    fork
      begin drive(0, 8'hA5, a1, r1); acc_first = a1; valid_v[0] = 1'b0; end
      check_stream(0, 1, "a5_thomas");
    join

    // IEEE, LSB first.
    fork
      begin drive(1, 8'hA5, a1, r1); acc_first = a1; valid_v[1] = 1'b0; end
      check_stream(1, 1, "a5_ieee_lsb");
    join

    // No gap: second frame must follow without an idle cycle.
    fork
      begin
        drive(2, 8'hFF, a1, r1); acc_first = a1;
        drive(2, 8'h00, a2, r2);
        valid_v[2] = 1'b0;
      end
      check_stream(2, 2, "b2b");
    join

    // Four preamble bits ahead of an all-zero frame.
    fork
      begin drive(3, 8'h00, a1, r1); acc_first = a1; valid_v[3] = 1'b0; end
      check_stream(3, 1, "preamble");
    join

    // Three frames with valid held: ready reopens after launch + 64 frame + 8 gap clocks.
    fork
      begin
        drive(0, 8'h5A, a1, r1); acc_first = a1;
        drive(0, 8'hC3, a2, r2);
        chk("hold_second_accept", 32'(a2 - a1), 32'd2);
        chk("hold_ready_fall", 32'(rdy_v[0]), 32'd0);
        drive(0, 8'h81, a3, r3);
        valid_v[0] = 1'b0;
        chk("hold_ready_rise", 32'(r3 - a1), 32'd73);
      end
      check_stream(0, 3, "hold3");
    join

    // Asynchronous reset in the middle of a data half-bit.
    drive(0, 8'hA5, a1, r1);
    valid_v[0] = 1'b0;
    fr0 = exp_q[0];
    repeat (22) @(negedge clk);
    chk("mid_frame_sdo", 32'(sdo_v[0]), 32'(fr0.h[5]));
    #1 rst = 1'b0;
    #1;
    chk("async_rst_sdo", 32'(sdo_v[0]), 32'd1);
    chk("async_rst_busy", 32'(busy_v[0]), 32'd0);
    chk("async_rst_ready", 32'(rdy_v[0]), 32'd1);
    chk("async_rst_done", 32'(done_v[0]), 32'd0);
    exp_q.delete();
    repeat (3) begin
      @(negedge clk);
      chk("rst_hold_done", 32'(done_v[0]), 32'd0);
    end
    rst = 1'b1;
    fork
      begin drive(0, 8'h3C, a1, r1); acc_first = a1; valid_v[0] = 1'b0; end
      check_stream(0, 1, "after_reset");
    join

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
